// File: rtl/alu_mux_pkg.sv
// Shared definitions for the N-input registered selector: operating modes,
// output-stage states and the channel-index wrap helper.
package alu_mux_pkg;

    // Source selection: external index or internal round-robin arbiter.
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Output register occupancy.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Next channel index after idx, wrapping from num_ch-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx,
                                             input int unsigned num_ch);
        return (idx >= num_ch - 1) ? 0 : idx + 1;
    endfunction

endpackage : alu_mux_pkg

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester found when
// searching upward from ptr (with wrap) wins.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int SELW   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SELW-1:0]   ptr,
    output logic [SELW-1:0]   gnt,
    output logic              gnt_vld
);

    localparam logic [SELW:0] NUM_CH_W = (SELW+1)'(NUM_CH);

    logic [NUM_CH-1:0] w_rot;
    logic [SELW-1:0]   w_off;
    logic              w_hit;
    logic [SELW:0]     w_sum;

    // Rotate requests so that bit 0 is the channel at ptr.
    assign w_rot = NUM_CH'({req, req} >> ptr);

    // Lowest set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_off = '0;
        w_hit = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SELW'(k);
                w_hit = 1'b1;
            end
        end
    end

    // Map the rotated offset back to an absolute channel index.
    assign w_sum   = {1'b0, ptr} + {1'b0, w_off};
    assign gnt     = (w_sum >= NUM_CH_W) ? SELW'(w_sum - NUM_CH_W) : w_sum[SELW-1:0];
    assign gnt_vld = w_hit;

endmodule : rr_arbiter

// File: rtl/mux_arb_nx.sv
// N-input, WIDTH-bit selector with a single registered output stage and
// valid/ready handshakes; the source is picked by an external index or by a
// fair round-robin arbiter whose pointer survives fixed-mode intervals.
module mux_arb_nx
    import alu_mux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int SELW   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SELW-1:0]         sel,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_ch,
    input  logic                    out_ready
);

    localparam logic [SELW:0] NUM_CH_W = (SELW+1)'(NUM_CH);

    out_state_e       r_state;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic [SELW-1:0]  r_ptr;

    logic             w_load_en;
    logic             w_fix_vld;
    logic [SELW-1:0]  w_rr_gnt;
    logic             w_rr_vld;
    logic [SELW-1:0]  w_gnt;
    logic             w_gnt_vld;
    logic [WIDTH-1:0] w_sel_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt     (w_rr_gnt),
        .gnt_vld (w_rr_vld)
    );

    // Output register can accept a word when empty or being drained this cycle.
    assign w_load_en = (r_state == OUT_EMPTY) || out_ready;

    // Fixed mode: an out-of-range index (non-power-of-2 NUM_CH) never grants.
    assign w_fix_vld = ({1'b0, sel} < NUM_CH_W) && in_valid[sel];

    // Mode and sel act on this cycle's grant with no pipeline delay.
    assign w_gnt     = (mode == MODE_RR) ? w_rr_gnt : sel;
    assign w_gnt_vld = (mode == MODE_RR) ? w_rr_vld : w_fix_vld;

    assign w_sel_data = in_data[w_gnt*WIDTH +: WIDTH];

    // One-hot (or zero) accept toward the granted producer; silent in reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = rst_n && w_load_en && w_gnt_vld && (w_gnt == SELW'(i));
        end
    end

    // Output stage and RR pointer: load on grant, drain when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= OUT_EMPTY;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_ptr      <= '0;
        end else if (w_load_en) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (w_gnt_vld) begin
                r_state    <= OUT_FULL;
                r_out_data <= w_sel_data;
                r_out_ch   <= w_gnt;
                if (mode == MODE_RR) begin
                    r_ptr <= SELW'(wrap_inc(32'(w_gnt), NUM_CH));
                end
            end else begin
                r_state <= OUT_EMPTY;
            end
        end
    end

    assign out_valid = (r_state == OUT_FULL);
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule : mux_arb_nx

// File: tb/tb_mux_arb_nx.sv
// Self-checking bench for mux_arb_nx: per-scenario tasks with inline checks on
// handshakes and held state, plus a scoreboard that receives every expected
// output word when stimulus is driven and compares it when the word leaves.
module tb_mux_arb_nx;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;
    localparam int SELW   = 2;

    typedef struct packed {
        logic [SELW-1:0]  ch;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    mode;
    logic [SELW-1:0]         sel;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SELW-1:0]         out_ch;
    logic                    out_ready;

    logic [WIDTH-1:0] dat [NUM_CH];
    exp_t             sb_q [$];
    int               total;
    int               bad;

    assign in_data = {dat[3], dat[2], dat[1], dat[0]};

    mux_arb_nx #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: a word is consumed at the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got ch=%0d data=%h, expected no word", out_ch, out_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (out_ch !== e.ch || out_data !== e.data) begin
                    bad++;
                    $display("FAIL sb_word: got ch=%0d data=%h, expected ch=%0d data=%h",
                             out_ch, out_data, e.ch, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [WIDTH-1:0] d);
        exp_t e;
        e.ch   = SELW'(ch);
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic chk_ready(input string name, input logic [NUM_CH-1:0] exp);
        total++;
        if (in_ready !== exp) begin
            bad++;
            $display("FAIL %s: in_ready=%b expected %b", name, in_ready, exp);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) dat[i] = WIDTH'(8'hE0 + i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h expected 00", out_data); end
        if (out_ch !== 2'd0)    begin bad++; $display("FAIL rst_ch: got %0d expected 0", out_ch); end
        if (in_ready !== 4'h0)  begin bad++; $display("FAIL rst_ready: got %b expected 0000", in_ready); end

        // Fill the output register, hold it, then reset asynchronously mid-cycle.
        step();
        rst_n     = 1'b1;
        sel       = 2'd2;
        in_valid  = 4'b0100;
        dat[2]    = 8'hA5;
        out_ready = 1'b0;
        step();
        in_valid = 4'b0000;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL async_pre_full: out_valid=%b expected 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid: out_valid=%b expected 0", out_valid); end
        if (out_data !== 8'h00) begin bad++; $display("FAIL async_data: got %h expected 00", out_data); end
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_fixed();
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        dat[0]   = 8'h01;
        dat[1]   = 8'h02;
        dat[2]   = 8'hA5;
        dat[3]   = 8'h04;
        push(2, 8'hA5);
        @(negedge clk);
        chk_ready("fix_ready_sel2", 4'b0100);
        step();
        sel = 2'd1;
        @(negedge clk);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL fix_latency: out_valid=%b expected 1", out_valid); end
        if (out_data !== 8'hA5) begin bad++; $display("FAIL fix_data: got %h expected a5", out_data); end
        if (out_ch !== 2'd2)    begin bad++; $display("FAIL fix_ch: got %0d expected 2", out_ch); end
        chk_ready("fix_ready_sel1_idle", 4'b0000);
        step();
        @(negedge clk);
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL fix_drain: out_valid=%b expected 0", out_valid); end
        if (out_data !== 8'hA5) begin bad++; $display("FAIL fix_drain_data: got %h expected a5", out_data); end
        if (out_ch !== 2'd2)    begin bad++; $display("FAIL fix_drain_ch: got %0d expected 2", out_ch); end
        step();
        in_valid = 4'b0000;
    endtask

    task automatic test_rr_fair();
        mode     = 1'b1;
        in_valid = 4'hF;
        for (int i = 0; i < NUM_CH; i++) dat[i] = WIDTH'(8'h10 + i);
        for (int k = 0; k < 6; k++) begin
            push(k % NUM_CH, WIDTH'(8'h10 + (k % NUM_CH)));
            @(negedge clk);
            chk_ready("rr_fair_ready", NUM_CH'(1 << (k % NUM_CH)));
            if (k > 0) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL rr_fair_rate: cycle %0d out_valid=%b expected 1", k, out_valid);
                end
            end
            step();
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        mode      = 1'b1;
        in_valid  = 4'b0010;
        dat[1]    = 8'h11;
        out_ready = 1'b0;
        push(1, 8'h11);
        @(negedge clk);
        chk_ready("bp_load_ready", 4'b0010);
        step();
        in_valid = 4'hF;
        for (int i = 0; i < NUM_CH; i++) dat[i] = WIDTH'(8'h10 + i);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_ready("bp_hold_ready", 4'b0000);
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
            if (out_data !== 8'h11) begin bad++; $display("FAIL bp_data: got %h expected 11", out_data); end
            if (out_ch !== 2'd1)    begin bad++; $display("FAIL bp_ch: got %0d expected 1", out_ch); end
            step();
        end
        out_ready = 1'b1;
        push(2, 8'h12);
        @(negedge clk);
        chk_ready("bp_resume_ready", 4'b0100);
        step();
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_sparse_wrap();
        mode     = 1'b1;
        in_valid = 4'b0010;
        dat[1]   = 8'h21;
        push(1, 8'h21);
        @(negedge clk);
        chk_ready("wrap_ready_ch1", 4'b0010);
        step();
        in_valid = 4'b0101;
        dat[0]   = 8'h30;
        dat[2]   = 8'h32;
        push(2, 8'h32);
        @(negedge clk);
        chk_ready("wrap_ready_ch2_first", 4'b0100);
        step();
        in_valid = 4'b0001;
        push(0, 8'h30);
        @(negedge clk);
        chk_ready("wrap_ready_ch0", 4'b0001);
        step();
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_mode_switch();
        mode     = 1'b1;
        in_valid = 4'b0010;
        dat[1]   = 8'h41;
        push(1, 8'h41);
        @(negedge clk);
        chk_ready("ms_rr_ch1", 4'b0010);
        step();
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b0001;
        dat[0]   = 8'h50;
        push(0, 8'h50);
        @(negedge clk);
        chk_ready("ms_fixed_1", 4'b0001);
        step();
        dat[0] = 8'h51;
        push(0, 8'h51);
        @(negedge clk);
        chk_ready("ms_fixed_2", 4'b0001);
        step();
        mode     = 1'b1;
        in_valid = 4'hF;
        for (int i = 0; i < NUM_CH; i++) dat[i] = WIDTH'(8'h60 + i);
        push(2, 8'h62);
        @(negedge clk);
        chk_ready("ms_rr_resume", 4'b0100);
        step();
        in_valid = 4'b0000;
        step();
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fixed();
        test_rr_fair();
        test_backpressure();
        test_sparse_wrap();
        test_mode_switch();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d words never appeared, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux_arb_nx

// File: doc/mux_arb_nx.md
Name: mux_arb_nx

Overview:
- Parametrised successor to the fixed 2:1 byte multiplexer: an NUM_CH-input, WIDTH-bit selector with a registered output stage and valid/ready handshakes.
- Two modes:
  - Fixed mode: an external select picks the source, like the combinational mux.
  - Round-robin mode: an internal fair arbiter picks the source.
- Sits in front of the ALU operand/result paths, where several producers share one consumer.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1).
- NUM_CH, 4, number of input channels (>=2).
- SELW, $clog2(NUM_CH), local: width of channel index; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_CH  per-channel data valid.
- in_data  in  NUM_CH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- in_ready  out  NUM_CH  per-channel accept; combinational from state and inputs.
- mode  in  1  0 = MODE_FIXED, 1 = MODE_RR.
- sel  in  SELW  channel index used in MODE_FIXED; ignored in MODE_RR.
- out_valid  out  1  output register holds valid data.
- out_data  out  WIDTH  registered selected data.
- out_ch  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync-to-clk deassert by the top level):
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer ptr=0.
  - in_ready=0 while rst_n=0.
- Output stage is a single register with two states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - load_en = !out_valid | out_ready.
- Grant (combinational, evaluated every cycle):
  - MODE_FIXED: gnt_vld = (sel < NUM_CH) & in_valid[sel]; gnt = sel. A sel >= NUM_CH (non-power-of-2 NUM_CH) gives no grant.
  - MODE_RR: search channels ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1, wrapping. The first channel with in_valid=1 is gnt and gnt_vld=1. If no channel is valid, gnt_vld=0.
- in_ready[i] = load_en & gnt_vld & (gnt==i). At most one bit is set (one-hot or zero).
- Transfer on channel i occurs when in_valid[i] & in_ready[i] at a clock edge. At that edge:
  - out_data <= in_data[i], out_ch <= i, out_valid <= 1.
  - In MODE_RR only, ptr <= (i==NUM_CH-1) ? 0 : i+1.
- If load_en & !gnt_vld: out_valid <= 0 (drains). out_data and out_ch hold their last values.
- If out_valid & !out_ready: out_data and out_ch are held stable, all in_ready=0, and ptr holds.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one word per cycle when out_ready is held at 1 (simultaneous drain and load in the same cycle).
- Mode switching:
  - A change of mode or sel takes effect on the same cycle's grant.
  - ptr is preserved across a MODE_FIXED interval and is never updated in MODE_FIXED.
- Data ordering: within one channel, data is never reordered or duplicated.
- Fairness: in MODE_RR, a continuously valid channel is granted within NUM_CH transfers.
- Reset mid-transfer: the output word is discarded and out_valid=0 immediately; no partial state is kept.

Decomposition:
- Shared package alu_mux_pkg holds:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1;
  - a function for the wrap-increment of a channel index.
- One sub-module, rr_arbiter:
  - parametrised by NUM_CH;
  - inputs: req, ptr;
  - outputs: gnt index, gnt_vld;
  - purely combinational.
- The output register, ptr register and fixed/RR grant select live in mux_arb_nx.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'hF -> out_valid=0, out_data=8'h00, out_ch=0, in_ready=4'h0. Assert rst_n=0 asynchronously mid-cycle while FULL -> out_valid falls without waiting for a clock edge.
- Fixed mode: mode=0, sel=2, in_valid=4'b0100, ch2 data 8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=8'hA5, out_ch=2. With sel=1 and in_valid[1]=0 -> no transfer; out_valid drops after the drain.
- Round-robin fairness: mode=1, all four channels continuously valid, channel i carrying 8'h10+i, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with matching data 8'h10..8'h13; one word per cycle.
- Backpressure: mode=1, out_ready=0 for 3 cycles while FULL with out_data=8'h11 -> in_ready=0, out_data/out_ch stable, ptr unchanged. On out_ready=1, the next grant follows the RR order.
- Sparse RR with wrap: ptr=3, in_valid=4'b0010 -> grant ch1 (wraps past 3 and 0), then ptr=2. Next request from ch0 and ch2 together -> ch2 is granted first.
- Mode-switch ptr retention: in RR after a grant to ch1 (ptr=2), switch to MODE_FIXED with sel=0 for 2 transfers, then return to RR with all channels valid -> the first RR grant is ch2.
